// File: rtl/csr_timer_bank.sv
// Eight-register CSR bank: 7-segment latches, IO, prescaled 2*WIDTH-bit counter,
// control, W1C status with maskable interrupt, and a full-state scan chain.
module csr_timer_bank #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] CTRL_RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             wr_enable,
    input  logic [WIDTH-1:0] IO_IN,
    input  logic             processor_enable,
    input  logic             scan_enable,
    input  logic             scan_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] SEGEXE_L_OUT,
    output logic [WIDTH-1:0] SEGEXE_H_OUT,
    output logic [WIDTH-1:0] IO_OUT,
    output logic             INT_OUT,
    output logic             scan_out
);
    localparam int PW = WIDTH - 4;
    localparam int CW = 2 * WIDTH;
    localparam int SW = 8 * WIDTH;

    logic [WIDTH-1:0] seg_l_q, seg_h_q, io_in_q, io_out_q;
    logic [WIDTH-1:0] cnt_l_q, cnt_h_q, ctrl_q, status_q;
    logic [WIDTH-1:0] seg_l_d, seg_h_d, io_in_d, io_out_d;
    logic [WIDTH-1:0] cnt_l_d, cnt_h_d, ctrl_d, status_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;

    logic [CW-1:0]    cnt, cnt_inc;
    logic [SW-1:0]    chain, chain_shifted;
    logic [WIDTH-1:0] w1c_mask;
    logic             tick, wr_cnt, ovf_set, iochg_set;

    assign cnt       = {cnt_h_q, cnt_l_q};
    assign cnt_inc   = cnt + CW'(1);
    assign tick      = processor_enable & ctrl_q[1] & (pcnt_q == ctrl_q[WIDTH-1:4]);
    assign wr_cnt    = wr_enable & ((addr == 3'd4) | (addr == 3'd5));
    // A software write to either counter half suppresses both the increment and OVF.
    assign ovf_set   = tick & ~wr_cnt & (&cnt);
    assign iochg_set = processor_enable & (IO_IN != io_in_q);

    always_comb begin
        seg_l_d  = seg_l_q;
        seg_h_d  = seg_h_q;
        io_in_d  = io_in_q;
        io_out_d = io_out_q;
        cnt_l_d  = cnt_l_q;
        cnt_h_d  = cnt_h_q;
        ctrl_d   = ctrl_q;
        pcnt_d   = pcnt_q;
        w1c_mask = '0;

        if (processor_enable & ctrl_q[1]) begin
            pcnt_d = tick ? '0 : pcnt_q + PW'(1);
        end
        if (processor_enable) begin
            io_in_d = IO_IN;
        end
        if (tick & ~wr_cnt) begin
            {cnt_h_d, cnt_l_d} = cnt_inc;
        end

        if (wr_enable) begin
            case (addr)
                3'd0: seg_l_d  = data_in;
                3'd1: seg_h_d  = data_in;
                3'd3: io_out_d = data_in;
                3'd4: cnt_l_d  = data_in;
                3'd5: cnt_h_d  = data_in;
                3'd6: begin
                    ctrl_d = data_in;
                    pcnt_d = '0;
                end
                3'd7: w1c_mask = data_in;
                default: ;
            endcase
        end

        // Hardware set is applied after the clear so a coincident event wins.
        status_d = (status_q & ~w1c_mask) | {{(WIDTH-2){1'b0}}, iochg_set, ovf_set};
    end

    assign chain         = {status_q, ctrl_q, cnt_h_q, cnt_l_q, io_out_q, io_in_q, seg_h_q, seg_l_q};
    assign chain_shifted = {chain[SW-2:0], scan_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_l_q  <= '0;
            seg_h_q  <= '0;
            io_in_q  <= '0;
            io_out_q <= '0;
            cnt_l_q  <= '0;
            cnt_h_q  <= '0;
            ctrl_q   <= CTRL_RESET;
            status_q <= '0;
            pcnt_q   <= '0;
        end else if (scan_enable) begin
            {status_q, ctrl_q, cnt_h_q, cnt_l_q, io_out_q, io_in_q, seg_h_q, seg_l_q} <= chain_shifted;
        end else begin
            seg_l_q  <= seg_l_d;
            seg_h_q  <= seg_h_d;
            io_in_q  <= io_in_d;
            io_out_q <= io_out_d;
            cnt_l_q  <= cnt_l_d;
            cnt_h_q  <= cnt_h_d;
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            pcnt_q   <= pcnt_d;
        end
    end

    always_comb begin
        data_out = '0;
        case (addr)
            3'd0: data_out = seg_l_q;
            3'd1: data_out = seg_h_q;
            3'd2: data_out = io_in_q;
            3'd3: data_out = io_out_q;
            3'd4: data_out = cnt_l_q;
            3'd5: data_out = cnt_h_q;
            3'd6: data_out = ctrl_q;
            3'd7: data_out = status_q;
            default: data_out = '0;
        endcase
    end

    assign SEGEXE_L_OUT = seg_l_q;
    assign SEGEXE_H_OUT = seg_h_q;
    assign IO_OUT       = io_out_q;
    assign INT_OUT      = ctrl_q[0] | (status_q[0] & ctrl_q[2]) | (status_q[1] & ctrl_q[3]);
    assign scan_out     = status_q[WIDTH-1];

endmodule

// File: tb/tb_csr_timer_bank.sv
// Self-checking bench for csr_timer_bank: directed scenarios plus randomized
// traffic compared against an arithmetic register-level model.
`timescale 1ns/1ps
module tb_csr_timer_bank;
    localparam int         W        = 8;
    localparam logic [7:0] CTRL_RST = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [7:0] data_in = 8'h00;
    logic       wr_enable = 1'b0;
    logic [7:0] IO_IN = 8'h00;
    logic       processor_enable = 1'b0;
    logic       scan_enable = 1'b0;
    logic       scan_in = 1'b0;
    logic [7:0] data_out, SEGEXE_L_OUT, SEGEXE_H_OUT, IO_OUT;
    logic       INT_OUT, scan_out;

    always #10 clk = ~clk;

    csr_timer_bank #(.WIDTH(W), .CTRL_RESET(CTRL_RST)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr_enable(wr_enable),
        .IO_IN(IO_IN), .processor_enable(processor_enable), .scan_enable(scan_enable),
        .scan_in(scan_in), .data_out(data_out), .SEGEXE_L_OUT(SEGEXE_L_OUT),
        .SEGEXE_H_OUT(SEGEXE_H_OUT), .IO_OUT(IO_OUT), .INT_OUT(INT_OUT), .scan_out(scan_out)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_reg [8];
    int unsigned m_pcnt;

    // Reference model: one clock edge, from the register-map rules.
    task automatic model_step();
        logic [7:0]  nr [8];
        logic [63:0] ch;
        int unsigned c, presc;
        bit          tk, cnt_wr, set_ovf, set_io;
        for (int k = 0; k < 8; k++) nr[k] = m_reg[k];
        if (rst) begin
            for (int k = 0; k < 8; k++) nr[k] = 8'h00;
            nr[6]  = CTRL_RST;
            m_pcnt = 0;
        end else if (scan_enable) begin
            for (int k = 0; k < 8; k++)
                for (int b = 0; b < 8; b++) ch[8*k+b] = m_reg[k][b];
            ch = {ch[62:0], scan_in};
            for (int k = 0; k < 8; k++)
                for (int b = 0; b < 8; b++) nr[k][b] = ch[8*k+b];
        end else begin
            presc   = 32'(m_reg[6][7:4]);
            c       = 256 * 32'(m_reg[5]) + 32'(m_reg[4]);
            tk      = processor_enable && m_reg[6][1] && (m_pcnt == presc);
            cnt_wr  = wr_enable && (addr == 3'd4 || addr == 3'd5);
            set_ovf = tk && !cnt_wr && (c == 65535);
            set_io  = processor_enable && (IO_IN != m_reg[2]);
            if (processor_enable && m_reg[6][1]) m_pcnt = tk ? 0 : m_pcnt + 1;
            if (tk && !cnt_wr) begin
                c     = (c + 1) % 65536;
                nr[4] = 8'(c % 256);
                nr[5] = 8'(c / 256);
            end
            if (processor_enable) nr[2] = IO_IN;
            if (wr_enable) begin
                case (addr)
                    3'd0, 3'd1, 3'd3, 3'd4, 3'd5: nr[addr] = data_in;
                    3'd6: begin nr[6] = data_in; m_pcnt = 0; end
                    3'd7: nr[7] = m_reg[7] & ~data_in;
                    default: ;
                endcase
            end
            if (set_ovf) nr[7][0] = 1'b1;
            if (set_io)  nr[7][1] = 1'b1;
        end
        for (int k = 0; k < 8; k++) m_reg[k] = nr[k];
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input int a, input logic [7:0] d);
        addr = 3'(a); data_in = d; wr_enable = 1'b1;
        step();
        wr_enable = 1'b0;
    endtask

    task automatic rd(input int a, output logic [7:0] v);
        addr = 3'(a);
        #1;
        v = data_out;
    endtask

    function automatic logic model_int();
        return m_reg[6][0] | (m_reg[7][0] & m_reg[6][2]) | (m_reg[7][1] & m_reg[6][3]);
    endfunction

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1; step(); step(); rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd(a, v);
            checks++;
            if (v !== 8'h00) begin errors++; $display("FAIL reset_read addr=%0d got=%h exp=00", a, v); end
        end
        checks++;
        if (INT_OUT !== 1'b0) begin errors++; $display("FAIL reset_int got=%b exp=0", INT_OUT); end
        checks++;
        if ({SEGEXE_L_OUT, SEGEXE_H_OUT, IO_OUT, scan_out} !== 25'h0) begin
            errors++; $display("FAIL reset_outs got=%h/%h/%h/%b exp=0", SEGEXE_L_OUT, SEGEXE_H_OUT, IO_OUT, scan_out);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] v;
        wr_reg(0, 8'h5A);
        checks++;
        if (SEGEXE_L_OUT !== 8'h5A) begin errors++; $display("FAIL seg_l_out got=%h exp=5A", SEGEXE_L_OUT); end
        rd(0, v); checks++;
        if (v !== 8'h5A) begin errors++; $display("FAIL seg_l_read got=%h exp=5A", v); end
        wr_reg(1, 8'hA5);
        checks++;
        if (SEGEXE_H_OUT !== 8'hA5) begin errors++; $display("FAIL seg_h_out got=%h exp=A5", SEGEXE_H_OUT); end
        wr_reg(3, 8'h3C);
        checks++;
        if (IO_OUT !== 8'h3C) begin errors++; $display("FAIL io_out got=%h exp=3C", IO_OUT); end
        wr_reg(2, 8'hFF);
        rd(2, v); checks++;
        if (v !== 8'h00 || v !== m_reg[2]) begin errors++; $display("FAIL io_in_ro got=%h exp=00", v); end
    endtask

    task automatic test_counter_ovf();
        logic [7:0] lo, hi, st;
        wr_reg(4, 8'hFE); wr_reg(5, 8'hFF); wr_reg(6, 8'h02);
        processor_enable = 1'b1;
        step();
        rd(4, lo); rd(5, hi); checks++;
        if ({hi, lo} !== 16'hFFFF) begin errors++; $display("FAIL cnt_ffff got=%h exp=FFFF", {hi, lo}); end
        step();
        processor_enable = 1'b0;
        rd(4, lo); rd(5, hi); rd(7, st); checks++;
        if ({hi, lo} !== 16'h0000) begin errors++; $display("FAIL cnt_wrap got=%h exp=0000", {hi, lo}); end
        checks++;
        if (st !== 8'h01) begin errors++; $display("FAIL ovf_set got=%h exp=01", st); end
        checks++;
        if (INT_OUT !== 1'b0) begin errors++; $display("FAIL ovf_masked_int got=%b exp=0", INT_OUT); end
        wr_reg(6, 8'h06);
        checks++;
        if (INT_OUT !== 1'b1) begin errors++; $display("FAIL ovf_int got=%b exp=1", INT_OUT); end
        wr_reg(7, 8'h01);
        rd(7, st); checks++;
        if (st !== 8'h00 || INT_OUT !== 1'b0) begin
            errors++; $display("FAIL ovf_w1c got=%h int=%b exp=00 int=0", st, INT_OUT);
        end
    endtask

    task automatic test_prescaler();
        logic [7:0] lo;
        wr_reg(4, 8'h00); wr_reg(5, 8'h00); wr_reg(6, 8'h32);
        processor_enable = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            rd(4, lo); checks++;
            if (lo !== 8'(k / 4) || lo !== m_reg[4]) begin
                errors++; $display("FAIL presc3 k=%0d got=%h exp=%h", k, lo, 8'(k / 4));
            end
        end
        processor_enable = 1'b0;
        repeat (5) step();
        rd(4, lo); checks++;
        if (lo !== 8'h03) begin errors++; $display("FAIL presc_freeze got=%h exp=03", lo); end
        processor_enable = 1'b1;
        step();
        rd(4, lo); checks++;
        if (lo !== 8'h03) begin errors++; $display("FAIL pcnt_hold got=%h exp=03", lo); end
        step();
        rd(4, lo); checks++;
        if (lo !== 8'h04) begin errors++; $display("FAIL pcnt_resume got=%h exp=04", lo); end
        processor_enable = 1'b0;
    endtask

    task automatic test_iochg();
        logic [7:0] v, st;
        wr_reg(6, 8'h08); wr_reg(7, 8'hFF);
        IO_IN = 8'h00; processor_enable = 1'b1;
        step();
        IO_IN = 8'h81;
        step();
        rd(2, v); rd(7, st); checks++;
        if (v !== 8'h81 || st !== 8'h02) begin errors++; $display("FAIL iochg_set io=%h st=%h exp=81/02", v, st); end
        checks++;
        if (INT_OUT !== 1'b1) begin errors++; $display("FAIL iochg_int got=%b exp=1", INT_OUT); end
        IO_IN = 8'h42;
        wr_reg(7, 8'h02);
        rd(7, st); rd(2, v); checks++;
        if (st !== 8'h02 || v !== 8'h42) begin errors++; $display("FAIL iochg_set_wins st=%h io=%h exp=02/42", st, v); end
        wr_reg(7, 8'h02);
        rd(7, st); checks++;
        if (st !== 8'h00 || INT_OUT !== 1'b0) begin errors++; $display("FAIL iochg_clear st=%h int=%b exp=00/0", st, INT_OUT); end
        processor_enable = 1'b0;
    endtask

    task automatic test_cnt_write_tick();
        logic [7:0] lo, hi, st;
        wr_reg(6, 8'h02); wr_reg(5, 8'h00); wr_reg(4, 8'hFF); wr_reg(7, 8'hFF);
        processor_enable = 1'b1;
        wr_reg(4, 8'h10);
        processor_enable = 1'b0;
        rd(4, lo); rd(5, hi); rd(7, st); checks++;
        if ({hi, lo} !== 16'h0010 || st !== 8'h00) begin errors++; $display("FAIL wr_lo_tick cnt=%h st=%h exp=0010/00", {hi, lo}, st); end
        wr_reg(5, 8'hFF); wr_reg(4, 8'hFF);
        processor_enable = 1'b1;
        wr_reg(5, 8'h12);
        processor_enable = 1'b0;
        rd(4, lo); rd(5, hi); rd(7, st); checks++;
        if ({hi, lo} !== 16'h12FF || st !== 8'h00) begin errors++; $display("FAIL wr_hi_tick cnt=%h st=%h exp=12FF/00", {hi, lo}, st); end
        processor_enable = 1'b1;
        step();
        processor_enable = 1'b0;
        rd(4, lo); rd(5, hi); checks++;
        if ({hi, lo} !== 16'h1300) begin errors++; $display("FAIL carry cnt=%h exp=1300", {hi, lo}); end
    endtask

    task automatic test_scan();
        logic [63:0] p;
        logic [7:0]  v, e, e6, e7;
        logic        ei;
        p = {$urandom, $urandom};
        processor_enable = 1'b1;
        scan_enable = 1'b1;
        for (int i = 0; i < 64; i++) begin
            scan_in = p[i]; IO_IN = 8'($urandom);
            step();
        end
        e6 = 8'h00; e7 = 8'h00;
        for (int k = 0; k < 8; k++) begin
            for (int b = 0; b < 8; b++) e[b] = p[63 - (8*k + b)];
            if (k == 6) e6 = e;
            if (k == 7) e7 = e;
            rd(k, v); checks++;
            if (v !== e || v !== m_reg[k]) begin errors++; $display("FAIL scan_load reg=%0d got=%h exp=%h", k, v, e); end
        end
        ei = e6[0] | (e7[0] & e6[2]) | (e7[1] & e6[3]);
        checks++;
        if (INT_OUT !== ei) begin errors++; $display("FAIL scan_int got=%b exp=%b", INT_OUT, ei); end
        for (int j = 0; j < 64; j++) begin
            checks++;
            if (scan_out !== p[j]) begin errors++; $display("FAIL scan_out bit=%0d got=%b exp=%b", j, scan_out, p[j]); end
            scan_in = 1'($urandom); IO_IN = 8'($urandom);
            step();
        end
        scan_enable = 1'b0;
        processor_enable = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rd(k, v); checks++;
            if (v !== m_reg[k]) begin errors++; $display("FAIL scan_unload reg=%0d got=%h exp=%h", k, v, m_reg[k]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        rst = 1'b1; step(); rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            rst              = ($urandom_range(0, 99) == 0);
            scan_enable      = ($urandom_range(0, 19) == 0);
            wr_enable        = 1'($urandom);
            addr             = 3'($urandom_range(0, 7));
            data_in          = 8'($urandom);
            if (addr == 3'd6) data_in = {4'($urandom_range(0, 1)), 4'($urandom)};
            if ((addr == 3'd4 || addr == 3'd5) && $urandom_range(0, 1) == 1) data_in = 8'hFF;
            if ($urandom_range(0, 3) == 0) IO_IN = 8'($urandom);
            processor_enable = ($urandom_range(0, 4) != 0);
            scan_in          = 1'($urandom);
            step();
            rst = 1'b0; wr_enable = 1'b0; scan_enable = 1'b0;
            for (int a = 0; a < 8; a++) begin
                rd(a, v); checks++;
                if (v !== m_reg[a]) begin errors++; $display("FAIL rand_reg cyc=%0d addr=%0d got=%h exp=%h", n, a, v, m_reg[a]); end
            end
            checks++;
            if (INT_OUT !== model_int()) begin errors++; $display("FAIL rand_int cyc=%0d got=%b exp=%b", n, INT_OUT, model_int()); end
            checks++;
            if ({SEGEXE_L_OUT, SEGEXE_H_OUT, IO_OUT, scan_out} !== {m_reg[0], m_reg[1], m_reg[3], m_reg[7][7]}) begin
                errors++; $display("FAIL rand_outs cyc=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", n,
                    SEGEXE_L_OUT, SEGEXE_H_OUT, IO_OUT, scan_out, m_reg[0], m_reg[1], m_reg[3], m_reg[7][7]);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 8; k++) m_reg[k] = 8'h00;
        m_pcnt = 0;
        #3;
        test_reset();
        test_write_read();
        test_counter_ovf();
        test_prescaler();
        test_iochg();
        test_cnt_write_tick();
        test_scan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_timer_bank.md
Name: csr_timer_bank

Overview:
Parametrised control/status register bank for the processor core. It provides eight WIDTH-bit registers: 7-segment latches, IO input/output, a 2*WIDTH-bit free-running counter with programmable prescaler, and a control register. It adds a write-1-to-clear status register with overflow and IO-change flags, plus a maskable interrupt. All storage sits on a single scan chain used for load/dump of processor state.

Parameters:
- WIDTH, 8, register width. Must be >= 8.
- CTRL_RESET, 0, reset value of the CTRL register (WIDTH bits).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  3  register select.
- data_in  input  WIDTH  write data.
- wr_enable  input  1  write strobe for the register at addr.
- IO_IN  input  WIDTH  external input pins.
- processor_enable  input  1  gates IO_IN sampling, counter and prescaler.
- scan_enable  input  1  scan shift mode.
- scan_in  input  1  scan chain input.
- data_out  output  WIDTH  combinational read of the register at addr.
- SEGEXE_L_OUT  output  WIDTH  register 0 contents.
- SEGEXE_H_OUT  output  WIDTH  register 1 contents.
- IO_OUT  output  WIDTH  register 3 contents.
- INT_OUT  output  1  interrupt request.
- scan_out  output  1  scan chain output.

Behaviour:
- Register map:
  - 0 SEGEXE_L (RW).
  - 1 SEGEXE_H (RW).
  - 2 IO_IN (RO; writes ignored).
  - 3 IO_OUT (RW).
  - 4 CNT_L (RW).
  - 5 CNT_H (RW).
  - 6 CTRL (RW).
  - 7 STATUS (W1C).
- CTRL fields:
  - [0] SW_INT.
  - [1] CNT_EN.
  - [2] OVF_IE.
  - [3] IOCHG_IE.
  - [WIDTH-1:4] PRESC.
- STATUS fields:
  - [0] OVF.
  - [1] IOCHG.
  - [WIDTH-1:2] hold their stored value; functional logic never sets them, W1C clears them.
- Reset: all registers 0, except CTRL = CTRL_RESET; prescale counter pcnt = 0. All outputs derive from registers, so SEGEXE_*, IO_OUT = 0 after reset.
- Priority per edge: rst > scan_enable > functional update.
- While scan_enable = 1:
  - The whole chain shifts one bit per cycle; no writes, sampling, counting or flag setting occur.
  - pcnt holds.
  - Chain order: scan_in -> reg0 bit0 ... reg0 bit WIDTH-1 -> reg1 bit0 ... -> reg7 bit WIDTH-1 -> scan_out. Length is 8*WIDTH.
  - scan_out = reg7[WIDTH-1] (combinational from flop).
- Writes take effect on the edge where wr_enable = 1; data is visible on data_out the next cycle.
- IO_IN register loads IO_IN every cycle processor_enable = 1. If the sampled value differs from the current register value, IOCHG is set the same edge.
- Prescaler, when processor_enable & CNT_EN:
  - If pcnt == PRESC: tick, and pcnt <= 0.
  - Otherwise pcnt <= pcnt + 1.
  - Result: the counter increments once per PRESC+1 enabled cycles (PRESC = 0 gives every cycle).
  - Otherwise pcnt holds. Any write to CTRL clears pcnt.
- Counter {CNT_H, CNT_L} is 2*WIDTH bits. On tick it adds 1 modulo 2^(2*WIDTH). Wrap from all-ones to 0 sets OVF.
- Write to CNT_L or CNT_H in the same cycle as a tick: the written half takes data_in, the other half holds, and no increment or OVF occurs that cycle.
- STATUS write: each bit written 1 is cleared. If hardware sets a flag on the same edge, the set wins.
- INT_OUT = SW_INT | (OVF & OVF_IE) | (IOCHG & IOCHG_IE), combinational from registers.
- data_out: a pure mux on addr; no read side effects.

Test Plan:
- Reset with CTRL_RESET = 8'h00 -> all reads return 0, INT_OUT = 0. Write 8'h5A to addr 0 -> SEGEXE_L_OUT = 8'h5A next cycle. Write addr 2 -> read unchanged.
- CTRL = 8'h02 (PRESC 0), processor_enable = 1, CNT preloaded 16'hFFFE -> counter reads FFFF, then 0000 with OVF = 1. Then CTRL = 8'h06 -> INT_OUT = 1. Write STATUS 8'h01 -> OVF = 0, INT_OUT = 0.
- CTRL = 8'h32 (PRESC = 3) -> counter increments every 4 cycles. Drop processor_enable for 5 cycles -> counter and pcnt frozen.
- IO_IN 8'h00 -> 8'h81 with CTRL = 8'h08 -> IO_IN reg = 8'h81 and IOCHG = 1 one edge later, INT_OUT = 1. W1C of IOCHG in the same cycle as a new IO_IN change -> IOCHG stays 1.
- Write CNT_L = 8'h10 on a tick cycle with CNT = 16'h00FF -> CNT = 16'h0010, no OVF.
- scan_enable for 64 cycles shifting a known pattern -> registers hold the pattern and INT_OUT reflects the scanned CTRL/STATUS. A further 64 shifts -> the original pattern emerges on scan_out, bit-ordered per the chain.
